pla_seq_eval: RTL and testbench

- Programmable, pipelined sum-of-products (PLA) evaluator: the sequential, parametrised successor to the fixed two-level benchmark logic blocks.
- Holds NUM_TERMS product terms over NUM_IN inputs, each ORed into any of NUM_OUT outputs.
- Accepts one input vector per cycle on a valid/ready stream and returns the output vector 2 cycles later.
- Sits between benchmark stimulus streams and result checkers; terms are loaded through a config port.

---
 rtl/pla_pkg.sv | 21 ++
 rtl/pla_term_match.sv | 15 +
 rtl/pla_seq_eval.sv | 135 +++++++++++++
 tb/tb_pla_seq_eval.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pla_pkg.sv
// rtl/pla_pkg.sv - shared widths, term record and helpers for the PLA evaluator
package pla_pkg;

  localparam int PLA_CNT_W     = 16;
  localparam int PLA_MAX_W     = 32;
  localparam int PLA_MAX_TERMS = 64;
  localparam int PLA_MAX_AW    = $clog2(PLA_MAX_TERMS + 1);

  // Fields are sized for the largest build; narrower builds zero-extend into them.
  typedef struct packed {
    logic [PLA_MAX_W-1:0] care;
    logic [PLA_MAX_W-1:0] pol;
    logic [PLA_MAX_W-1:0] out;
  } pla_term_t;

  // Config address width: one slot per term plus the inversion slot.
  function automatic int pla_addr_w(input int terms);
    return $clog2(terms + 1);
  endfunction

endpackage

// File: rtl/pla_term_match.sv
// rtl/pla_term_match.sv - combinational single product-term compare
module pla_term_match
  import pla_pkg::*;
#(
  parameter int W = 10
) (
  input  logic [W-1:0] care_i,
  input  logic [W-1:0] pol_i,
  input  logic [W-1:0] in_data_i,
  output logic         hit_o
);

  assign hit_o = &((in_data_i ~^ pol_i) | ~care_i);

endmodule

// File: rtl/pla_seq_eval.sv
// rtl/pla_seq_eval.sv - two-stage programmable sum-of-products evaluator
// Optional output inversion register enabled by defining PLA_OUT_INV_EN.
module pla_seq_eval
  import pla_pkg::*;
#(
  parameter int NUM_IN    = 10,
  parameter int NUM_OUT   = 7,
  parameter int NUM_TERMS = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               cfg_we,
  input  logic [pla_addr_w(NUM_TERMS)-1:0]   cfg_addr,
  input  logic [NUM_IN-1:0]                  cfg_care,
  input  logic [NUM_IN-1:0]                  cfg_pol,
  input  logic [NUM_OUT-1:0]                 cfg_out,
  output logic                               cfg_ready,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [NUM_IN-1:0]                  in_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [NUM_OUT-1:0]                 out_data,
  output logic [PLA_CNT_W-1:0]               out_count
);

  localparam int AW = pla_addr_w(NUM_TERMS);

  pla_term_t              term_q [NUM_TERMS];
  logic [NUM_TERMS-1:0]   hit_d;
  logic [NUM_TERMS-1:0]   hit_q;
  logic                   s1_valid_q;
  logic                   s2_valid_q;
  logic [NUM_OUT-1:0]     out_d;
  logic [NUM_OUT-1:0]     out_q;
  logic [PLA_CNT_W-1:0]   cnt_q;
  logic                   s2_free;
  logic                   s1_adv;
  logic                   accept;
  logic                   cfg_wr;
  logic [NUM_TERMS-1:0]   term_par;
  logic                   unused_term_par;

  assign s2_free   = !s2_valid_q || out_ready;
  assign s1_adv    = s1_valid_q && s2_free;
  assign in_ready  = !s1_valid_q || s1_adv;
  assign accept    = in_valid && in_ready;
  assign cfg_ready = !s1_valid_q && !s2_valid_q && !in_valid;
  assign cfg_wr    = cfg_we && cfg_ready;

  assign out_valid = s2_valid_q;
  assign out_data  = out_q;
  assign out_count = cnt_q;

  for (genvar k = 0; k < NUM_TERMS; k++) begin : g_term
    pla_term_match #(.W(NUM_IN)) u_match (
      .care_i    (term_q[k].care[NUM_IN-1:0]),
      .pol_i     (term_q[k].pol[NUM_IN-1:0]),
      .in_data_i (in_data),
      .hit_o     (hit_d[k])
    );
    assign term_par[k] = ^term_q[k];
  end

  // Upper record bits beyond NUM_IN/NUM_OUT are always zero.
  assign unused_term_par = ^term_par;

`ifdef PLA_OUT_INV_EN
  logic [NUM_OUT-1:0] inv_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inv_q <= '0;
    end else if (cfg_wr && cfg_addr == AW'(NUM_TERMS)) begin
      inv_q <= cfg_out;
    end
  end
`endif

  always_comb begin
    out_d = '0;
    for (int j = 0; j < NUM_OUT; j++) begin
      for (int k = 0; k < NUM_TERMS; k++) begin
        out_d[j] = out_d[j] | (hit_q[k] & term_q[k].out[j]);
      end
    end
`ifdef PLA_OUT_INV_EN
    out_d = out_d ^ inv_q;
`endif
  end

  // Writes only land while the pipe is empty, so in-flight vectors never see them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_TERMS; k++) term_q[k] <= '0;
    end else if (cfg_wr) begin
      for (int k = 0; k < NUM_TERMS; k++) begin
        if (cfg_addr == AW'(k)) begin
          term_q[k].care <= PLA_MAX_W'(cfg_care);
          term_q[k].pol  <= PLA_MAX_W'(cfg_pol);
          term_q[k].out  <= PLA_MAX_W'(cfg_out);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      hit_q      <= '0;
      s2_valid_q <= 1'b0;
      out_q      <= '0;
      cnt_q      <= '0;
    end else begin
      if (accept) begin
        hit_q      <= hit_d;
        s1_valid_q <= 1'b1;
      end else if (s1_adv) begin
        s1_valid_q <= 1'b0;
      end

      if (s1_adv) begin
        out_q      <= out_d;
        s2_valid_q <= 1'b1;
      end else if (s2_valid_q && out_ready) begin
        s2_valid_q <= 1'b0;
      end

      if (s2_valid_q && out_ready && cnt_q != '1) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_pla_seq_eval.sv
// tb/tb_pla_seq_eval.sv - directed table-driven bench for pla_seq_eval
module tb_pla_seq_eval;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic [4:0]  cfg_addr = '0;
  logic [9:0]  cfg_care = '0;
  logic [9:0]  cfg_pol = '0;
  logic [6:0]  cfg_out = '0;
  logic        cfg_ready;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [9:0]  in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [6:0]  out_data;
  logic [15:0] out_count;

  pla_seq_eval dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_care  (cfg_care),
    .cfg_pol   (cfg_pol),
    .cfg_out   (cfg_out),
    .cfg_ready (cfg_ready),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] din;
    logic [6:0] dout;
  } vec_t;

  vec_t tbl [16];
  int   n_checks = 0;
  int   n_fail = 0;
  int   exp_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_cfg(input logic [4:0] a, input logic [9:0] c, input logic [9:0] p,
                           input logic [6:0] o);
    bit done = 0;
    cfg_we = 1'b1; cfg_addr = a; cfg_care = c; cfg_pol = p; cfg_out = o;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cfg_ready) begin
        tick();
        done = 1;
        break;
      end
      tick();
    end
    cfg_we = 1'b0;
    check("cfg_accept", 32'(done), 32'd1);
  endtask

  // Back-to-back vectors; each result must appear exactly two cycles after its drive.
  task automatic run_vecs(input int s, input int n);
    for (int c = 0; c < n + 2; c++) begin
      if (c < n) begin
        in_valid = 1'b1;
        in_data  = tbl[s+c].din;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (c < n) check("in_ready_stream", 32'(in_ready), 32'd1);
      if (c >= 2) begin
        check("out_valid_lat", 32'(out_valid), 32'd1);
        check($sformatf("out_data_vec%0d", s + c - 2), 32'(out_data), 32'(tbl[s+c-2].dout));
      end
      tick();
    end
    in_valid = 1'b0;
    exp_count += n;
  endtask

  initial begin
    int acc;
    int ng;
    bit seen;
    bit done;
    logic [6:0] got [8];
    vec_t bp [3];

    tbl[0]  = '{10'h000, 7'h00};
    tbl[1]  = '{10'h3FF, 7'h00};
    tbl[2]  = '{10'h100, 7'h01};
    tbl[3]  = '{10'h180, 7'h00};
    tbl[4]  = '{10'h080, 7'h00};
    tbl[5]  = '{10'h000, 7'h05};
    tbl[6]  = '{10'h100, 7'h05};
    tbl[7]  = '{10'h200, 7'h00};
    tbl[8]  = '{10'h300, 7'h01};
    tbl[9]  = '{10'h001, 7'h45};
    tbl[10] = '{10'h000, 7'h05};
    tbl[11] = '{10'h001, 7'h00};
`ifdef PLA_OUT_INV_EN
    tbl[12] = '{10'h000, 7'h7F};
    tbl[13] = '{10'h100, 7'h7E};
`else
    tbl[12] = '{10'h000, 7'h00};
    tbl[13] = '{10'h100, 7'h01};
`endif
    tbl[14] = '{10'h000, 7'h00};
    tbl[15] = '{10'h000, 7'h00};

    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", 32'(in_ready), 32'd1);
    check("idle_cfg_ready", 32'(cfg_ready), 32'd1);
    tick();

    run_vecs(0, 2);
    check("count_unconfigured", 32'(out_count), 32'(exp_count));

    write_cfg(5'd0, 10'h180, 10'h100, 7'h01);
    run_vecs(2, 3);
    write_cfg(5'd1, 10'h200, 10'h000, 7'h05);
    run_vecs(5, 4);
    check("count_after_terms", 32'(out_count), 32'(exp_count));

    // Stall with input held: only two vectors fit before in_ready drops.
    bp[0] = tbl[6]; bp[1] = tbl[8]; bp[2] = tbl[7];
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = bp[0].din;
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      if (out_valid) check("bp_hold_data", 32'(out_data), 32'(bp[0].dout));
      tick();
      if (acc < 3) in_data = bp[acc].din;
    end
    check("bp_absorbed", 32'(acc), 32'd2);
    @(negedge clk);
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    check("bp_out_data", 32'(out_data), 32'(bp[0].dout));
    tick();
    out_ready = 1'b1;
    ng = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      if (out_valid && out_ready && ng < 8) begin
        got[ng] = out_data;
        ng++;
      end
      tick();
      if (acc >= 3) in_valid = 1'b0;
    end
    check("bp_drain_count", 32'(ng), 32'd3);
    for (int i = 0; i < 3; i++) check($sformatf("bp_drain%0d", i), 32'(got[i]), 32'(bp[i].dout));
    exp_count += 3;

    // Config raised together with a vector: must wait for the pipe to empty.
    in_valid = 1'b1; in_data = 10'h001;
    cfg_we = 1'b1; cfg_addr = 5'd2; cfg_care = 10'h001; cfg_pol = 10'h001; cfg_out = 7'h40;
    @(negedge clk);
    check("cfg_busy_in_valid", 32'(cfg_ready), 32'd0);
    tick();
    in_valid = 1'b0;
    seen = 0;
    done = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) check("cfg_busy_s1", 32'(cfg_ready), 32'd0);
      if (out_valid) begin
        check("cfg_inflight_data", 32'(out_data), 32'h05);
        seen = 1;
      end
      if (cfg_ready) begin
        tick();
        done = 1;
        break;
      end
      tick();
    end
    cfg_we = 1'b0;
    check("cfg_inflight_seen", 32'(seen), 32'd1);
    check("cfg_landed_idle", 32'(done), 32'd1);
    exp_count += 1;
    run_vecs(9, 2);
    check("count_before_rst", 32'(out_count), 32'(exp_count));

    // Asynchronous reset with two vectors in flight.
    in_valid = 1'b1; in_data = 10'h001;
    tick();
    in_data = 10'h000;
    tick();
    rst = 1'b1;
    #1;
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check("rst_mid_count", 32'(out_count), 32'd0);
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    exp_count = 0;
    @(negedge clk);
    check("rst_mid_cfg_ready", 32'(cfg_ready), 32'd1);
    tick();
    run_vecs(11, 1);

    write_cfg(5'd16, 10'h000, 10'h000, 7'h7F);
    write_cfg(5'd20, 10'h000, 10'h000, 7'h7F);
    run_vecs(12, 1);
    write_cfg(5'd0, 10'h180, 10'h100, 7'h01);
    run_vecs(13, 1);
    check("count_final", 32'(out_count), 32'(exp_count));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
